// File: rtl/addsub_arbiter_pkg.sv
// Shared types and constants for the two-requester add/subtract arbiter.
package addsub_arbiter_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/addsub_arbiter_addsub.sv
// Ripple-free N-bit adder/subtractor: sub_i=1 computes a-b as a + ~b + 1,
// so cout_o=1 on subtract means no borrow.
module adder_subtractor #(
    parameter int N = 4
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         sub_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);

    logic [N-1:0] b_eff_s;
    logic [N:0]   total_s;

    // Conditional inversion of b with the carry-in supplying the +1 of two's complement.
    always_comb begin
        b_eff_s = b_i ^ {N{sub_i}};
        total_s = {1'b0, a_i} + {1'b0, b_eff_s} + {{N{1'b0}}, sub_i};
    end

    assign sum_o  = total_s[N-1:0];
    assign cout_o = total_s[N];

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin front end sharing one adder_subtractor between two requesters,
// with IDLE -> EXEC -> RESP sequencing and a held, registered response.
module addsub_arbiter
    import addsub_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_valid_i,
    output logic [NUM_REQ-1:0] req_ready_o,
    input  logic [N-1:0]       req_a0_i,
    input  logic [N-1:0]       req_b0_i,
    input  logic [N-1:0]       req_a1_i,
    input  logic [N-1:0]       req_b1_i,
    input  logic [NUM_REQ-1:0] req_sub_i,
    output logic [NUM_REQ-1:0] rsp_valid_o,
    input  logic [NUM_REQ-1:0] rsp_ready_i,
    output logic [N-1:0]       rsp_sum_o,
    output logic               rsp_cout_o,
    output logic               rsp_ovf_o,
    output logic               busy_o
);

    typedef struct packed {
        logic [N-1:0] sum;
        logic         cout;
        logic         ovf;
    } rsp_t;

    // Both valid: the priority holder wins; otherwise the lone valid requester.
    function automatic logic rr_pick(input logic [NUM_REQ-1:0] valid, input logic prio);
        logic pick;
        if (valid == 2'b11) begin
            pick = prio;
        end else if (valid[1]) begin
            pick = 1'b1;
        end else begin
            pick = 1'b0;
        end
        return pick;
    endfunction

    state_t             state_q, state_d;
    logic               prio_q, prio_d;
    logic               grant_q, grant_d;
    logic [N-1:0]       a_q, a_d;
    logic [N-1:0]       b_q, b_d;
    logic               sub_q, sub_d;
    rsp_t               rsp_q, rsp_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic               busy_q, busy_d;

    logic [NUM_REQ-1:0] req_ready_s;
    logic               pick_s;
    logic [N-1:0]       b_eff_s;
    logic [N-1:0]       sum_s;
    logic               cout_s;

    adder_subtractor #(
        .N(N)
    ) u_addsub (
        .a_i    (a_q),
        .b_i    (b_q),
        .sub_i  (sub_q),
        .sum_o  (sum_s),
        .cout_o (cout_s)
    );

    // Next-state, operand capture and response generation.
    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        grant_d     = grant_q;
        a_d         = a_q;
        b_d         = b_q;
        sub_d       = sub_q;
        rsp_d       = rsp_q;
        rsp_valid_d = rsp_valid_q;
        req_ready_s = 2'b00;
        pick_s      = rr_pick(req_valid_i, prio_q);
        b_eff_s     = b_q ^ {N{sub_q}};

        case (state_q)
            IDLE: begin
                if (req_valid_i != 2'b00) begin
                    req_ready_s[pick_s] = 1'b1;
                    grant_d             = pick_s;
                    a_d                 = pick_s ? req_a1_i : req_a0_i;
                    b_d                 = pick_s ? req_b1_i : req_b0_i;
                    sub_d               = req_sub_i[pick_s];
                    state_d             = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                rsp_d.sum   = sum_s;
                rsp_d.cout  = cout_s;
                // Signed overflow: operands agree in sign but the result does not.
                rsp_d.ovf   = (a_q[N-1] == b_eff_s[N-1]) && (sum_s[N-1] != a_q[N-1]);
                rsp_valid_d = grant_q ? 2'b10 : 2'b01;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready_i[grant_q]) begin
                    rsp_valid_d = 2'b00;
                    prio_d      = ~grant_q;
                    state_d     = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                rsp_valid_d = 2'b00;
                state_d     = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            grant_q     <= 1'b0;
            a_q         <= {N{1'b0}};
            b_q         <= {N{1'b0}};
            sub_q       <= 1'b0;
            rsp_q       <= '0;
            rsp_valid_q <= 2'b00;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            grant_q     <= grant_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sub_q       <= sub_d;
            rsp_q       <= rsp_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Accept is combinational, so it is masked while reset is applied.
    assign req_ready_o = rst_i ? 2'b00 : req_ready_s;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_sum_o   = rsp_q.sum;
    assign rsp_cout_o  = rsp_q.cout;
    assign rsp_ovf_o   = rsp_q.ovf;
    assign busy_o      = busy_q;

endmodule
